// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback and drives datapath selects, enables and the 2-bit ALUOp.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       pc_en,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t     cur;
    logic [5:0] op_q;
    logic       illegal_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur       <= FETCH;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            case (cur)
                FETCH:  if (mem_ready) cur <= DECODE;
                DECODE: begin
                    op_q <= opcode;
                    case (opcode)
                        OP_LW, OP_SW: cur <= MEMADR;
                        OP_RTYPE:     cur <= EXEC;
                        OP_BEQ:       cur <= BRANCH;
                        OP_J:         cur <= JUMP;
                        OP_ADDI:      cur <= ADDIEX;
                        default: begin
                            cur       <= FETCH;
                            illegal_q <= 1'b1;
                        end
                    endcase
                end
                // Only lw or sw can reach MEMADR, so the held opcode picks the direction.
                MEMADR: cur <= (op_q == OP_SW) ? MEMWR : MEMRD;
                MEMRD:  if (mem_ready) cur <= MEMWB;
                MEMWR:  if (mem_ready) cur <= FETCH;
                EXEC:   cur <= ALUWB;
                ADDIEX: cur <= ADDIWB;
                default: cur <= FETCH;
            endcase
        end
    end

    // Outputs decode straight from the state so that reset can blank them in the same cycle.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        if (!reset) begin
            case (cur)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                DECODE: ALUSrcB = 2'b11;
                MEMADR, ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                ALUWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                ADDIWB: RegWrite = 1'b1;
                BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign pc_en      = PCWrite | (PCWriteCond & zero);
    assign illegal_op = illegal_q & ~reset;
    assign state      = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control: per-instruction state/control traces,
// memory stalls, illegal opcode and reset mid-instruction.
module tb_multicycle_control;

    logic       clk, reset, zero, mem_ready;
    logic [5:0] opcode;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
    logic       ALUSrcA, RegWrite, RegDst, pc_en, illegal_op;
    logic [1:0] PCSource, ALUSrcB, ALUOp;
    logic [3:0] state;
    logic [17:0] ctrl;

    int checks = 0;
    int errors = 0;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
        .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .pc_en(pc_en), .illegal_op(illegal_op), .state(state)
    );

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,RegWrite,RegDst,
    //  PCSource,ALUSrcB,ALUOp,pc_en,illegal_op}
    assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA,
                   RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, pc_en, illegal_op};

    localparam logic [17:0] E_ZERO   = '0;
    localparam logic [17:0] E_FETCH  = {10'b1001001000, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0};
    localparam logic [17:0] E_FSTALL = {10'b0001000000, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] E_FILL   = {10'b0001000000, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1};
    localparam logic [17:0] E_DECODE = {10'b0000000000, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] E_ADR    = {10'b0000000100, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] E_MEMRD  = {10'b0011000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] E_MEMWB  = {10'b0000010010, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] E_MEMWR  = {10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] E_EXEC   = {10'b0000000100, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0};
    localparam logic [17:0] E_ALUWB  = {10'b0000000011, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] E_ADDIWB = {10'b0000000010, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] E_BR_T   = {10'b0100000100, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0};
    localparam logic [17:0] E_BR_F   = {10'b0100000100, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0};
    localparam logic [17:0] E_JUMP   = {10'b1000000000, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each test starts in the low phase of a FETCH cycle and ends in the low phase of the next FETCH.
    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1; opcode = 6'b000000; zero = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++;
        if (ctrl !== E_ZERO) begin errors++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, E_ZERO); end
        reset = 1'b0; #1;
        checks++;
        if (ctrl !== E_FETCH) begin errors++; $display("FAIL reset_release_ctrl: got %b expected %b", ctrl, E_FETCH); end
    endtask

    task automatic test_rtype();
        logic [3:0] st [5]; logic [17:0] cv [5]; logic mr [5];
        st = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        cv = '{E_FETCH, E_DECODE, E_EXEC, E_ALUWB, E_FETCH};
        mr = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        opcode = 6'b000000; zero = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mem_ready = mr[i]; #1;
            checks++;
            if (state !== st[i]) begin errors++; $display("FAIL rtype_state[%0d]: got %0d expected %0d", i, state, st[i]); end
            checks++;
            if (ctrl !== cv[i]) begin errors++; $display("FAIL rtype_ctrl[%0d]: got %b expected %b", i, ctrl, cv[i]); end
            if (i < 4) @(negedge clk);
        end
    endtask

    task automatic test_lw_stall();
        logic [3:0] st [8]; logic [17:0] cv [8]; logic mr [8]; logic [5:0] op [8];
        st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
        cv = '{E_FETCH, E_DECODE, E_ADR, E_MEMRD, E_MEMRD, E_MEMRD, E_MEMWB, E_FETCH};
        mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        // opcode switches to sw after DECODE; the held lw opcode must still steer to MEMRD
        op = '{6'b100011, 6'b100011, 6'b101011, 6'b101011, 6'b101011, 6'b101011, 6'b101011, 6'b101011};
        zero = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mem_ready = mr[i]; opcode = op[i]; #1;
            checks++;
            if (state !== st[i]) begin errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, st[i]); end
            checks++;
            if (ctrl !== cv[i]) begin errors++; $display("FAIL lw_ctrl[%0d]: got %b expected %b", i, ctrl, cv[i]); end
            if (i < 7) @(negedge clk);
        end
    endtask

    task automatic test_beq(input logic z);
        logic [3:0] st [4]; logic [17:0] cv [4];
        st = '{4'd0, 4'd1, 4'd8, 4'd0};
        cv = '{E_FETCH, E_DECODE, z ? E_BR_T : E_BR_F, E_FETCH};
        opcode = 6'b000100; zero = z; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (state !== st[i]) begin errors++; $display("FAIL beq%0d_state[%0d]: got %0d expected %0d", z, i, state, st[i]); end
            checks++;
            if (ctrl !== cv[i]) begin errors++; $display("FAIL beq%0d_ctrl[%0d]: got %b expected %b", z, i, ctrl, cv[i]); end
            if (i < 3) @(negedge clk);
        end
    endtask

    task automatic test_jump();
        logic [3:0] st [4]; logic [17:0] cv [4];
        st = '{4'd0, 4'd1, 4'd9, 4'd0};
        cv = '{E_FETCH, E_DECODE, E_JUMP, E_FETCH};
        opcode = 6'b000010; zero = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (state !== st[i]) begin errors++; $display("FAIL j_state[%0d]: got %0d expected %0d", i, state, st[i]); end
            checks++;
            if (ctrl !== cv[i]) begin errors++; $display("FAIL j_ctrl[%0d]: got %b expected %b", i, ctrl, cv[i]); end
            if (i < 3) @(negedge clk);
        end
    endtask

    task automatic test_sw_fetch_stall();
        logic [3:0] st [6]; logic [17:0] cv [6]; logic mr [6];
        st = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
        cv = '{E_FSTALL, E_FETCH, E_DECODE, E_ADR, E_MEMWR, E_FETCH};
        mr = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        opcode = 6'b101011; zero = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mem_ready = mr[i]; #1;
            checks++;
            if (state !== st[i]) begin errors++; $display("FAIL sw_state[%0d]: got %0d expected %0d", i, state, st[i]); end
            checks++;
            if (ctrl !== cv[i]) begin errors++; $display("FAIL sw_ctrl[%0d]: got %b expected %b", i, ctrl, cv[i]); end
            if (i < 5) @(negedge clk);
        end
    endtask

    task automatic test_addi();
        logic [3:0] st [5]; logic [17:0] cv [5];
        st = '{4'd0, 4'd1, 4'd10, 4'd11, 4'd0};
        cv = '{E_FETCH, E_DECODE, E_ADR, E_ADDIWB, E_FETCH};
        opcode = 6'b001000; zero = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (state !== st[i]) begin errors++; $display("FAIL addi_state[%0d]: got %0d expected %0d", i, state, st[i]); end
            checks++;
            if (ctrl !== cv[i]) begin errors++; $display("FAIL addi_ctrl[%0d]: got %b expected %b", i, ctrl, cv[i]); end
            if (i < 4) @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        logic [3:0] st [4]; logic [17:0] cv [4]; logic mr [4];
        st = '{4'd0, 4'd1, 4'd0, 4'd0};
        cv = '{E_FETCH, E_DECODE, E_FILL, E_FSTALL};
        mr = '{1'b1, 1'b1, 1'b0, 1'b0};
        opcode = 6'b111111; zero = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_ready = mr[i]; #1;
            checks++;
            if (state !== st[i]) begin errors++; $display("FAIL illegal_state[%0d]: got %0d expected %0d", i, state, st[i]); end
            checks++;
            if (ctrl !== cv[i]) begin errors++; $display("FAIL illegal_ctrl[%0d]: got %b expected %b", i, ctrl, cv[i]); end
            if (i < 3) @(negedge clk);
        end
        mem_ready = 1'b1; #1;
    endtask

    task automatic test_reset_mid_memwr();
        logic [3:0] st [5]; logic [17:0] cv [5]; logic mr [5];
        st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
        cv = '{E_FETCH, E_DECODE, E_ADR, E_MEMWR, E_MEMWR};
        mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        opcode = 6'b101011; zero = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mem_ready = mr[i]; #1;
            checks++;
            if (state !== st[i]) begin errors++; $display("FAIL rst_sw_state[%0d]: got %0d expected %0d", i, state, st[i]); end
            checks++;
            if (ctrl !== cv[i]) begin errors++; $display("FAIL rst_sw_ctrl[%0d]: got %b expected %b", i, ctrl, cv[i]); end
            if (i < 4) @(negedge clk);
        end
        reset = 1'b1; #1;
        checks++;
        if (ctrl !== E_ZERO) begin errors++; $display("FAIL rst_sw_blank: got %b expected %b", ctrl, E_ZERO); end
        @(negedge clk); #1;
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL rst_sw_state_after: got %0d expected 0", state); end
        reset = 1'b0; mem_ready = 1'b1; opcode = 6'b000000; #1;
        checks++;
        if (ctrl !== E_FETCH) begin errors++; $display("FAIL rst_sw_resume_ctrl: got %b expected %b", ctrl, E_FETCH); end
        @(negedge clk); #1;
        checks++;
        if (state !== 4'd1) begin errors++; $display("FAIL rst_sw_resume_state: got %0d expected 1", state); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_beq(1'b1);
        test_beq(1'b0);
        test_jump();
        test_sw_fetch_stall();
        test_addi();
        test_illegal();
        test_reset_mid_memwr();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
